// File: rtl/io_bank_ccff_cfg_ctrl.sv
// io_bank_ccff_cfg_ctrl: shadow ccff chain with checked atomic commit and serial readback for an IO bank
module io_bank_ccff_cfg_ctrl #(
  parameter int NUM_CH = 4,
  parameter int NUM_CLK = 16,
  parameter int MODE_BITS = 2,
  localparam int SEL_W = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1,
  localparam int CW = SEL_W + MODE_BITS,
  localparam int L = NUM_CH * CW,
  localparam int CNT_W = $clog2(L + 2)
) (
  input  logic                        prog_clock,
  input  logic                        global_reset,
  input  logic                        config_enable,
  input  logic                        ccff_head,
  input  logic                        readback_req,
  output logic                        ccff_tail,
  output logic [NUM_CH*SEL_W-1:0]     ch_clk_sel,
  output logic [NUM_CH*MODE_BITS-1:0] ch_mode,
  output logic                        cfg_done,
  output logic                        cfg_err
);
  localparam logic [CNT_W-1:0] LEN = CNT_W'(L);
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(L + 1);
  localparam logic [SEL_W:0] NCLK = (SEL_W + 1)'(NUM_CLK);
  logic [L-1:0] chain_q, chain_d, rb_word;
  logic [NUM_CH*SEL_W-1:0] sel_q, sel_d, sel_n;
  logic [NUM_CH*MODE_BITS-1:0] mode_q, mode_d, mode_n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic en_q, done_q, done_d, err_q, err_d, ok, commit;
  assign ccff_tail = chain_q[L-1];
  assign ch_clk_sel = sel_q;
  assign ch_mode = mode_q;
  assign cfg_done = done_q;
  assign cfg_err = err_q;
  // Unpack the shadow chain, range-check every select field, and decide the next state
  always_comb begin
    sel_n = '0;
    mode_n = '0;
    rb_word = '0;
    ok = (cnt_q == LEN);
    for (int c = 0; c < NUM_CH; c++) begin
      sel_n[c*SEL_W +: SEL_W] = chain_q[c*CW +: SEL_W];
      mode_n[c*MODE_BITS +: MODE_BITS] = chain_q[c*CW+SEL_W +: MODE_BITS];
      rb_word[c*CW +: CW] = {mode_q[c*MODE_BITS +: MODE_BITS], sel_q[c*SEL_W +: SEL_W]};
      ok = ok && ({1'b0, chain_q[c*CW +: SEL_W]} < NCLK);
    end
    commit = !config_enable && en_q;
    chain_d = config_enable ? {chain_q[L-2:0], ccff_head} : (!en_q && readback_req) ? rb_word : chain_q;
    cnt_d = config_enable ? ((cnt_q == MAXC) ? cnt_q : cnt_q + 1'b1) : en_q ? '0 : cnt_q;
    sel_d = (commit && ok) ? sel_n : sel_q;
    mode_d = (commit && ok) ? mode_n : mode_q;
    done_d = commit && ok;
    err_d = config_enable ? (err_q && en_q) : commit ? !ok : err_q;
  end
  // State registers; reset aborts any shift in progress
  always_ff @(posedge prog_clock) begin
    if (global_reset) begin
      chain_q <= '0;
      sel_q <= '0;
      mode_q <= '0;
      cnt_q <= '0;
      en_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      chain_q <= chain_d;
      sel_q <= sel_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      en_q <= config_enable;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_io_bank_ccff_cfg_ctrl.sv
// tb_io_bank_ccff_cfg_ctrl: randomized and directed bench against a stream-level reference model
module tb_io_bank_ccff_cfg_ctrl;
  localparam int L = 24;
  logic clk = 1'b0;
  logic rst, en, head, rb;
  logic [1:0] tail, done, err;
  logic [15:0] sel [2];
  logic [7:0] mode [2];
  int checks = 0, errors = 0;
  int ncl [2] = '{16, 12};
  bit ch_m [2][L];
  int sel_m [2][4], mode_m [2][4], cnt_m, done_m [2], err_m [2];
  bit enp;
  logic [23:0] w2, w5, wr;
  always #5 clk = ~clk;
  io_bank_ccff_cfg_ctrl #(.NUM_CH(4), .NUM_CLK(16), .MODE_BITS(2)) dut16 (
    .prog_clock(clk), .global_reset(rst), .config_enable(en), .ccff_head(head), .readback_req(rb),
    .ccff_tail(tail[0]), .ch_clk_sel(sel[0]), .ch_mode(mode[0]), .cfg_done(done[0]), .cfg_err(err[0]));
  io_bank_ccff_cfg_ctrl #(.NUM_CH(4), .NUM_CLK(12), .MODE_BITS(2)) dut12 (
    .prog_clock(clk), .global_reset(rst), .config_enable(en), .ccff_head(head), .readback_req(rb),
    .ccff_tail(tail[1]), .ch_clk_sel(sel[1]), .ch_mode(mode[1]), .cfg_done(done[1]), .cfg_err(err[1]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] enc(int m3, int s3, int m2, int s2, int m1, int s1, int m0, int s0);
    return {2'(m3), 4'(s3), 2'(m2), 4'(s2), 2'(m1), 4'(s1), 2'(m0), 4'(s0)};
  endfunction
  // stream index 0 is the oldest bit shifted in, i.e. chain bit L-1
  task automatic model(input bit r, input bit e, input bit h, input bit b);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        for (int i = 0; i < L; i++) ch_m[d][i] = 0;
        for (int c = 0; c < 4; c++) begin sel_m[d][c] = 0; mode_m[d][c] = 0; end
        done_m[d] = 0;
        err_m[d] = 0;
      end else begin
        done_m[d] = 0;
        if (e) begin
          for (int i = 0; i < L - 1; i++) ch_m[d][i] = ch_m[d][i+1];
          ch_m[d][L-1] = h;
          if (!enp) err_m[d] = 0;
        end else if (enp) begin
          bit ok = (cnt_m == L);
          int w [4];
          for (int k = 0; k < 4; k++) begin
            w[k] = 0;
            for (int j = 0; j < 6; j++) w[k] = w[k] * 2 + int'(ch_m[d][k*6+j]);
            if (w[k] % 16 >= ncl[d]) ok = 0;
          end
          if (ok) for (int k = 0; k < 4; k++) begin sel_m[d][3-k] = w[k] % 16; mode_m[d][3-k] = w[k] / 16; end
          done_m[d] = ok;
          err_m[d] = !ok;
        end else if (b) begin
          for (int k = 0; k < 4; k++) begin
            int v = mode_m[d][3-k] * 16 + sel_m[d][3-k];
            for (int j = 0; j < 6; j++) ch_m[d][k*6+j] = bit'((v >> (5 - j)) & 1);
          end
        end
      end
    end
    cnt_m = r ? 0 : e ? ((cnt_m == L + 1) ? cnt_m : cnt_m + 1) : enp ? 0 : cnt_m;
    enp = r ? 0 : e;
  endtask
  task automatic cmp_all;
    for (int d = 0; d < 2; d++) begin
      int es = 0, em = 0;
      for (int c = 0; c < 4; c++) begin es |= sel_m[d][c] << (4 * c); em |= mode_m[d][c] << (2 * c); end
      chk($sformatf("tail%0d", d), 32'(tail[d]), 32'(ch_m[d][0]));
      chk($sformatf("sel%0d", d), 32'(sel[d]), es);
      chk($sformatf("mode%0d", d), 32'(mode[d]), em);
      chk($sformatf("done%0d", d), 32'(done[d]), done_m[d]);
      chk($sformatf("err%0d", d), 32'(err[d]), err_m[d]);
    end
  endtask
  task automatic step(input bit r, input bit e, input bit h, input bit b);
    rst = r; en = e; head = h; rb = b;
    model(r, e, h, b);
    @(negedge clk);
    cmp_all();
  endtask
  task automatic shift_word(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) step(0, 1, (i < 24) ? w[23-i] : 1'($urandom), 0);
  endtask
  initial begin
    enp = 0;
    cnt_m = 0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1'($urandom), 0);
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    chk("t1_tail", 32'(tail[0]), 0);
    chk("t1_sel", 32'(sel[0]), 0);
    chk("t1_mode", 32'(mode[0]), 0);
    chk("t1_done", 32'(done[0]), 0);
    chk("t1_err", 32'(err[0]), 0);
    w2 = enc(1, 15, 3, 0, 0, 9, 2, 5);
    shift_word(w2, 24);
    step(0, 0, 0, 0);
    chk("t2_sel", 32'(sel[0]), 32'h F095);
    chk("t2_mode", 32'(mode[0]), 32'h72);
    chk("t2_done", 32'(done[0]), 1);
    chk("t2_err", 32'(err[0]), 0);
    step(0, 0, 0, 0);
    chk("t2_done_pulse", 32'(done[0]), 0);
    wr = 24'($urandom);
    shift_word(wr, 23);
    step(0, 0, 0, 0);
    chk("t3_short_err", 32'(err[0]), 1);
    chk("t3_short_done", 32'(done[0]), 0);
    chk("t3_short_sel", 32'(sel[0]), 32'h F095);
    step(0, 0, 0, 0);
    shift_word(wr, 25);
    step(0, 0, 0, 0);
    chk("t3_long_err", 32'(err[0]), 1);
    chk("t3_long_mode", 32'(mode[0]), 32'h72);
    shift_word(w2, 24);
    step(0, 0, 0, 0);
    chk("t3_ok_err", 32'(err[0]), 0);
    chk("t3_ok_done", 32'(done[0]), 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("t4_tail0", 32'(tail[0]), 32'(w2[23]));
    for (int k = 1; k <= 24; k++) begin
      step(0, 1, 0, 0);
      if (k < 24) chk($sformatf("t4_tail%0d", k), 32'(tail[0]), 32'(w2[23-k]));
    end
    step(0, 0, 0, 0);
    chk("t4_sel", 32'(sel[0]), 0);
    chk("t4_done", 32'(done[0]), 1);
    w5 = enc(1, 7, 3, 0, 0, 13, 2, 5);
    shift_word(w5, 24);
    step(0, 0, 0, 0);
    chk("t5_bad_err", 32'(err[1]), 1);
    chk("t5_bad_sel", 32'(sel[1]), 0);
    chk("t5_bad_ok16", 32'(sel[0]), 32'h 70D5);
    w5 = enc(1, 7, 3, 0, 0, 11, 2, 5);
    shift_word(w5, 24);
    step(0, 0, 0, 0);
    chk("t5_ok_err", 32'(err[1]), 0);
    chk("t5_ok_sel", 32'(sel[1]), 32'h 70B5);
    chk("t5_ok_mode", 32'(mode[1]), 32'h72);
    for (int i = 0; i < 10; i++) step(0, 1, 1'($urandom), 0);
    step(1, 1, 1'($urandom), 0);
    for (int i = 0; i < 14; i++) step(0, 1, 1'($urandom), 1);
    step(0, 0, 0, 0);
    chk("t6_err", 32'(err[0]), 1);
    chk("t6_sel", 32'(sel[0]), 0);
    chk("t6_mode", 32'(mode[0]), 0);
    for (int b = 0; b < 40; b++) begin
      int n = ($urandom_range(0, 1) == 1) ? 24 : $urandom_range(18, 30);
      for (int i = 0; i < n; i++) step(0, 1, 1'($urandom), 1'($urandom));
      for (int i = 0; i < $urandom_range(1, 3); i++) step($urandom_range(0, 30) == 0, 0, 1'($urandom), 1'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
